// File: rtl/edge_pkg.sv
// Shared types and helpers for the edge/pulse transmitter.
package edge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    // Shortest phase a 2-flop synchroniser on the receive side can reliably see.
    localparam int MIN_WIDTH_DEF = 2;

    // Raise a requested phase width to the minimum that will not be missed.
    function automatic int unsigned clamp_width(input int unsigned w, input int unsigned min_w);
        return (w < min_w) ? min_w : w;
    endfunction

endpackage

// File: rtl/phase_counter.sv
// Loadable down-counter that times one high or low phase; stops at zero.
module phase_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    // Load has priority; decrement saturates at zero so the count never wraps.
    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (dec && count != '0)
            count <= count - CNT_W'(1);
    end

    assign zero = (count == '0);

endmodule

// File: rtl/edge_pulse_gen.sv
// Burst pulse transmitter: N pulses of H high / L low cycles, with edge strobes.
module edge_pulse_gen
    import edge_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter int NUM_W     = 8,
    parameter int MIN_WIDTH = MIN_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] high_cycles,
    input  logic [CNT_W-1:0] low_cycles,
    input  logic [NUM_W-1:0] num_pulses,
    input  logic             abort,
    output logic             data_out,
    output logic             rise_strobe,
    output logic             fall_strobe,
    output logic             busy,
    output logic             done,
    output logic             aborted
);

    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);
    localparam logic [NUM_W-1:0] ONE_N = NUM_W'(1);

    state_t           state;
    logic [CNT_W-1:0] h_reg, l_reg;
    logic [NUM_W-1:0] pulse_cnt;
    logic             ab_flag;

    logic [CNT_W-1:0] h_in, l_in;
    logic             ph_load, ph_dec, ph_zero;
    logic [CNT_W-1:0] ph_val;
    logic             accept;
    logic             end_req;

    assign h_in    = CNT_W'(clamp_width(32'(high_cycles), MIN_WIDTH));
    assign l_in    = CNT_W'(clamp_width(32'(low_cycles),  MIN_WIDTH));
    assign accept  = start && !abort;
    // A pending or fresh abort stops any further pulse from being issued.
    assign end_req = ab_flag || abort;

    phase_counter #(.CNT_W(CNT_W)) u_phase (
        .clk      (clk),
        .rst      (rst),
        .load     (ph_load),
        .load_val (ph_val),
        .dec      (ph_dec),
        .zero     (ph_zero)
    );

    // Phase counter control: reload width-1 on every phase entry, else count down.
    always_comb begin
        ph_load = 1'b0;
        ph_dec  = 1'b0;
        ph_val  = l_reg - ONE_C;
        case (state)
            IDLE: begin
                if (accept && num_pulses != '0) begin
                    ph_load = 1'b1;
                    ph_val  = h_in - ONE_C;
                end
            end
            HIGH: begin
                if (abort || ph_zero) begin
                    ph_load = 1'b1;
                    ph_val  = l_reg - ONE_C;
                end else begin
                    ph_dec = 1'b1;
                end
            end
            LOW: begin
                if (ph_zero) begin
                    if (pulse_cnt != '0 && !end_req) begin
                        ph_load = 1'b1;
                        ph_val  = h_reg - ONE_C;
                    end
                end else begin
                    ph_dec = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Burst FSM with all outputs registered; strobes default low each cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            h_reg       <= '0;
            l_reg       <= '0;
            pulse_cnt   <= '0;
            ab_flag     <= 1'b0;
            data_out    <= 1'b0;
            rise_strobe <= 1'b0;
            fall_strobe <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            aborted     <= 1'b0;
        end else begin
            rise_strobe <= 1'b0;
            fall_strobe <= 1'b0;
            done        <= 1'b0;
            aborted     <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        h_reg     <= h_in;
                        l_reg     <= l_in;
                        pulse_cnt <= num_pulses;
                        ab_flag   <= 1'b0;
                        if (num_pulses == '0) begin
                            done <= 1'b1;
                        end else begin
                            state       <= HIGH;
                            data_out    <= 1'b1;
                            rise_strobe <= 1'b1;
                            busy        <= 1'b1;
                        end
                    end
                end
                HIGH: begin
                    if (abort || ph_zero) begin
                        state       <= LOW;
                        data_out    <= 1'b0;
                        fall_strobe <= 1'b1;
                        ab_flag     <= end_req;
                        if (pulse_cnt != '0)
                            pulse_cnt <= pulse_cnt - ONE_N;
                    end
                end
                LOW: begin
                    ab_flag <= end_req;
                    if (ph_zero) begin
                        if (pulse_cnt != '0 && !end_req) begin
                            state       <= HIGH;
                            data_out    <= 1'b1;
                            rise_strobe <= 1'b1;
                        end else begin
                            state   <= IDLE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            aborted <= end_req;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
